// File: rtl/proc_pkg.sv
// Shared definitions for the program loader and the processor program-RAM interface.
// Holds the loader state encoding and the program word geometry.
package proc_pkg;

  localparam int          PROG_ADDR_W = 10;
  localparam int          INSTR_W     = 16;
  localparam logic [15:0] HALT_INSTR  = 16'h3c00;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_LEN_HI  = 3'd1,
    LD_LEN_LO  = 3'd2,
    LD_DATA_HI = 3'd3,
    LD_DATA_LO = 3'd4,
    LD_CHK     = 3'd5,
    LD_DONE    = 3'd6,
    LD_ERR     = 3'd7
  } ld_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Joins a high/low byte pair into a 16-bit program word with a one-cycle write strobe,
// and keeps the running XOR of every frame byte seen since the last clear.
module byte_word_packer
  import proc_pkg::*;
#(
  parameter int ADDR_W = PROG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              byte_en_i,
  input  logic              hi_en_i,
  input  logic              lo_en_i,
  input  logic [7:0]        byte_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [15:0]       din_o,
  output logic [7:0]        xor_o
);

  logic [7:0]        hi_q;
  logic [7:0]        xor_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      xor_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else if (clear_i) begin
      // a restart drops any byte accepted in the same cycle
      hi_q  <= '0;
      xor_q <= '0;
      we_q  <= 1'b0;
    end else begin
      we_q <= lo_en_i;
      if (byte_en_i) xor_q <= xor_q ^ byte_i;
      if (hi_en_i)   hi_q  <= byte_i;
      if (lo_en_i) begin
        addr_q <= addr_i;
        din_q  <= {hi_q, byte_i};
      end
    end
  end

  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign din_o  = din_q;
  assign xor_o  = xor_q;

endmodule

// File: rtl/prog_loader.sv
// Frame-receiving loader for the 16x1024 program RAM: length, word payload, XOR checksum,
// then releases the processor through start.
//
// state      | meaning
// IDLE       | after reset, waiting for load_req
// LEN_HI     | expecting frame length high byte
// LEN_LO     | expecting frame length low byte, length checked here
// DATA_HI    | expecting high byte of next word
// DATA_LO    | expecting low byte, word written on the following cycle
// CHK        | expecting checksum byte
// DONE       | load good, start held high
// ERR        | bad length or checksum, load_err held high
module prog_loader
  import proc_pkg::*;
#(
  parameter int ADDR_W    = PROG_ADDR_W,
  parameter int DATA_W    = INSTR_W,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              start,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  ld_state_e       state_q, state_d;
  logic [7:0]      len_hi_q, len_hi_d;
  logic [15:0]     len_q, len_d;
  logic [ADDR_W:0] wl_q, wl_d;
  logic            start_q, start_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            accept;
  logic            clear, byte_en, hi_en, lo_en;
  logic [15:0]     n_full;
  logic [7:0]      xor_cur;

  assign rx_ready = (state_q == LD_LEN_HI) || (state_q == LD_LEN_LO) ||
                    (state_q == LD_DATA_HI) || (state_q == LD_DATA_LO) ||
                    (state_q == LD_CHK);
  assign busy     = rx_ready;
  assign accept   = rx_valid && rx_ready;
  assign n_full   = {len_hi_q, rx_data};

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    wl_d     = wl_q;
    start_d  = start_q;
    done_d   = 1'b0;
    err_d    = err_q;
    clear    = 1'b0;
    byte_en  = 1'b0;
    hi_en    = 1'b0;
    lo_en    = 1'b0;

    if (load_req) begin
      state_d = LD_LEN_HI;
      wl_d    = '0;
      start_d = 1'b0;
      err_d   = 1'b0;
      clear   = 1'b1;
    end else if (accept) begin
      byte_en = (state_q != LD_CHK);
      unique case (state_q)
        LD_LEN_HI: begin
          len_hi_d = rx_data;
          state_d  = LD_LEN_LO;
        end
        LD_LEN_LO: begin
          len_d = n_full;
          if (n_full != 16'd0 && n_full <= MAX_N) begin
            state_d = LD_DATA_HI;
          end else begin
            state_d = LD_ERR;
            err_d   = 1'b1;
          end
        end
        LD_DATA_HI: begin
          hi_en   = 1'b1;
          state_d = LD_DATA_LO;
        end
        LD_DATA_LO: begin
          lo_en   = 1'b1;
          wl_d    = wl_q + 1'b1;
          state_d = (16'(wl_q) + 16'd1 == len_q) ? LD_CHK : LD_DATA_HI;
        end
        LD_CHK: begin
          if (rx_data == xor_cur) begin
            state_d = LD_DONE;
            start_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = LD_ERR;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LD_IDLE;
      len_hi_q <= '0;
      len_q    <= '0;
      wl_q     <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      wl_q     <= wl_d;
      start_q  <= start_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  byte_word_packer #(.ADDR_W(ADDR_W)) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear),
    .byte_en_i (byte_en),
    .hi_en_i   (hi_en),
    .lo_en_i   (lo_en),
    .byte_i    (rx_data),
    .addr_i    (wl_q[ADDR_W-1:0]),
    .we_o      (ram_write_en),
    .addr_o    (ram_addr),
    .din_o     (ram_din),
    .xor_o     (xor_cur)
  );

  assign start        = start_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: frames are described as byte lists and every
// accepted byte is scored against what the frame rules say must happen next cycle.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_req = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        ram_write_en;
  logic [9:0]  ram_addr;
  logic [15:0] ram_din;
  logic        busy;
  logic        start;
  logic        load_done;
  logic        load_err;
  logic [10:0] words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_req     (load_req),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .busy         (busy),
    .start        (start),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Builds a frame of n random words; bad flips the checksum.
  task automatic gen_frame(input int n, input bit bad, output logic [7:0] f[$]);
    logic [7:0] x;
    f = {};
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) f.push_back(8'($urandom));
    x = 8'h00;
    foreach (f[i]) x ^= f[i];
    f.push_back(bad ? (x ^ 8'(1 + $urandom_range(254))) : x);
  endtask

  task automatic pulse_load(input bit with_byte);
    @(negedge clk);
    load_req = 1'b1;
    rx_valid = with_byte;
    rx_data  = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    load_req = 1'b0;
    rx_valid = 1'b0;
    check_eq("restart_busy", 32'(busy), 1);
    check_eq("restart_start", 32'(start), 0);
    check_eq("restart_err", 32'(load_err), 0);
    check_eq("restart_words", 32'(words_loaded), 0);
    check_eq("restart_we", 32'(ram_write_en), 0);
    check_eq("restart_ready", 32'(rx_ready), 1);
  endtask

  // Sends the first nsend bytes of frame f with random idle cycles; caller is at a negedge.
  task automatic run_frame(input logic [7:0] f[$], input int nsend, input int gap_pct);
    int         k, n, cyc, limit, word;
    bit         legal, acc, exp_we, finished, good;
    logic [7:0] x;
    n        = int'({f[0], f[1]});
    legal    = (n >= 1) && (n <= 1024);
    k        = 0;
    cyc      = 0;
    x        = 8'h00;
    finished = 1'b0;
    good     = 1'b0;
    limit    = 20 * nsend + 100;
    while (k < nsend && !finished) begin
      acc      = ($urandom_range(99) >= gap_pct);
      rx_valid = acc;
      rx_data  = acc ? f[k] : 8'($urandom);
      check_eq("rx_ready", 32'(rx_ready), 1);
      @(posedge clk);
      @(negedge clk);
      exp_we = acc && legal && (k >= 3) && (k <= 2 * n + 1) && (k % 2 == 1);
      check_eq("write_en", 32'(ram_write_en), 32'(exp_we));
      if (exp_we) begin
        word = (k - 3) / 2;
        check_eq("write_addr", 32'(ram_addr), 32'(word));
        check_eq("write_data", 32'(ram_din), 32'({f[k-1], f[k]}));
        check_eq("words_loaded", 32'(words_loaded), 32'(word + 1));
      end
      if (acc) begin
        if (k == 1 && !legal) begin
          finished = 1'b1;
          check_eq("len_err", 32'(load_err), 1);
          check_eq("len_busy", 32'(busy), 0);
          check_eq("len_start", 32'(start), 0);
          check_eq("len_done", 32'(load_done), 0);
        end else if (k == 2 * n + 2) begin
          finished = 1'b1;
          good = (f[k] == x);
          check_eq("end_done", 32'(load_done), 32'(good));
          check_eq("end_start", 32'(start), 32'(good));
          check_eq("end_err", 32'(load_err), 32'(!good));
          check_eq("end_busy", 32'(busy), 0);
          check_eq("end_words", 32'(words_loaded), 32'(n));
        end else begin
          check_eq("mid_done", 32'(load_done), 0);
        end
        x ^= f[k];
        k++;
      end
      cyc++;
      if (cyc > limit) begin
        check_eq("timeout", 32'(cyc), 32'(limit));
        break;
      end
    end
    rx_valid = 1'b0;
    if (finished) begin
      // further offered bytes must be refused; done is a single pulse
      for (int i = 0; i < 3; i++) begin
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        check_eq("post_ready", 32'(rx_ready), 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("post_done", 32'(load_done), 0);
        check_eq("post_we", 32'(ram_write_en), 0);
        check_eq("post_start", 32'(start), 32'(good));
      end
      rx_valid = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] nominal[$];
    nominal = {8'h00, 8'h02, 8'h12, 8'h34, 8'h3C, 8'h00, 8'h18};

    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_ready", 32'(rx_ready), 0);
    check_eq("rst_start", 32'(start), 0);
    check_eq("rst_we", 32'(ram_write_en), 0);
    check_eq("rst_words", 32'(words_loaded), 0);
    check_eq("rst_err", 32'(load_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    pulse_load(1'b0);
    run_frame(nominal, nominal.size(), 0);

    // reload after a good run also covers the bad checksum frame
    pulse_load(1'b0);
    f = nominal;
    f[6] = 8'h19;
    run_frame(f, f.size(), 0);

    pulse_load(1'b0);
    f = {8'h00, 8'h00};
    run_frame(f, 2, 0);
    pulse_load(1'b0);
    f = {8'h04, 8'h01};
    run_frame(f, 2, 0);

    pulse_load(1'b0);
    run_frame(nominal, nominal.size(), 40);

    // abort in DATA_LO with a byte offered in the same cycle
    pulse_load(1'b0);
    gen_frame(5, 1'b0, f);
    run_frame(f, 5, 30);
    pulse_load(1'b1);
    gen_frame(4, 1'b0, f);
    run_frame(f, f.size(), 20);

    for (int t = 0; t < 8; t++) begin
      pulse_load(1'b0);
      gen_frame(1 + $urandom_range(19), ($urandom_range(2) == 0), f);
      run_frame(f, f.size(), $urandom_range(50));
    end

    pulse_load(1'b0);
    gen_frame(1024, 1'b0, f);
    run_frame(f, f.size(), 0);

    pulse_load(1'b0);
    gen_frame(6, 1'b0, f);
    run_frame(f, 7, 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_ready", 32'(rx_ready), 0);
    check_eq("mid_rst_we", 32'(ram_write_en), 0);
    check_eq("mid_rst_words", 32'(words_loaded), 0);
    check_eq("mid_rst_addr", 32'(ram_addr), 0);
    check_eq("mid_rst_din", 32'(ram_din), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_eq("idle_ready", 32'(rx_ready), 0);
      check_eq("idle_busy", 32'(busy), 0);
      check_eq("idle_we", 32'(ram_write_en), 0);
    end
    rx_valid = 1'b0;
    pulse_load(1'b0);
    run_frame(nominal, nominal.size(), 25);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
